// File: rtl/led_cnt_ctrl_if.sv
// APB3 bus bundle for the led_cnt host-side register controller.
//
// Signals:
//   psel, penable, pwrite  APB3 control, driven by the master
//   paddr[3:0]             byte address (bits [1:0] are ignored by the slave)
//   pwdata[31:0]           write data
//   prdata[31:0]           read data, driven by the slave
//   pready                 ready, driven by the slave
//   pslverr                error response, driven by the slave
//
// Modports: master (bus initiator) and slave (led_cnt_ctrl).

interface led_cnt_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );
endinterface

// File: rtl/led_cnt_ctrl.sv
// Host-side register controller for the led_cnt reconfigurable partition.
//
// An APB3 slave exposing four word registers:
//   0x0 DIV     RW  [11:0] divider; a write pulses wren_o for one cycle
//   0x4 SNAP    RO  int_cnt_i captured at the last accepted interrupt edge
//   0x8 STATUS  W1C bit0 pending, bit1 clr_tmo (sticky), bit2 clr_busy (RO)
//   0xC CTRL    RW  bit0 irq_en, [15:8] miss_cnt (RO), write bit16=1 clears miss_cnt
//
// Rising edges of led_int_i set `pending` (and snapshot int_cnt_i); irq_o is the
// registered AND of pending and irq_en. Clearing `pending` through STATUS starts
// a handshake: int_clr_o is held for CLR_LEN cycles, then the partition is given
// up to CLR_TMO cycles to drop led_int_i before clr_tmo is flagged.
//
// Ports:
//   clk100          single clock
//   rstn            asynchronous active-low reset
//   apb             APB3 slave (led_cnt_ctrl_if.slave), zero wait states
//   div_o[11:0]     divider value to the partition
//   wren_o          one-cycle divider load strobe
//   int_clr_o       interrupt clear to the partition
//   int_cnt_i[31:0] partition interrupt count
//   led_int_i       partition interrupt level (synchronous to clk100)
//   irq_o           registered CPU interrupt
//
// Parameters:
//   CLR_LEN  cycles int_clr_o is held high per clear (1..15)
//   CLR_TMO  cycles to wait for led_int_i to fall before flagging a timeout (>= 1)
//
// Build option:
//   LED_CTRL_MISS_CNT_EN  when defined, CTRL[15:8] is a saturating 8-bit count of
//                         edges that arrived while `pending` was already set;
//                         otherwise the counter is absent and reads 0.

module led_cnt_ctrl #(
    parameter int unsigned CLR_LEN = 4,
    parameter int unsigned CLR_TMO = 255
) (
    input  logic          clk100,
    input  logic          rstn,
    led_cnt_ctrl_if.slave apb,
    output logic [11:0]   div_o,
    output logic          wren_o,
    output logic          int_clr_o,
    input  logic [31:0]   int_cnt_i,
    input  logic          led_int_i,
    output logic          irq_o
);

    typedef enum logic [1:0] {StIdle, StClr, StWait} state_e;

    // WAIT counts 0..CLR_TMO-1 cycles.
    localparam int unsigned TmoW = (CLR_TMO > 1) ? $clog2(CLR_TMO) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(CLR_TMO - 1);
    localparam logic [3:0]      LenLast = 4'(CLR_LEN - 1);

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       access;
    logic       wr;
    logic [1:0] addr;
    logic       wr_div;
    logic       wr_snap;
    logic       wr_stat;
    logic       wr_ctrl;

    assign access  = apb.psel & apb.penable;
    assign wr      = access & apb.pwrite;
    assign addr    = apb.paddr[3:2];
    assign wr_div  = wr & (addr == 2'd0);
    assign wr_snap = wr & (addr == 2'd1);
    assign wr_stat = wr & (addr == 2'd2);
    assign wr_ctrl = wr & (addr == 2'd3);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [3:0]      len_cnt_q, len_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_hit;

    logic [11:0] div_q;
    logic        wren_q;
    logic        pending_q, pending_d;
    logic [31:0] snap_q;
    logic        clr_tmo_q, clr_tmo_d;
    logic        irq_en_q;
    logic        irq_q;
    logic        led_q;
    logic        clr_q;
    logic [7:0]  miss_cnt;

    logic busy;
    logic rise;
    logic edge_acc;
    logic set_pend;
    logic miss_event;
    logic w1c_pend;
    logic start_clr;
    logic clr_miss;

    assign busy       = (state_q != StIdle);
    assign rise       = led_int_i & ~led_q;
    // Edges seen while a clear is in flight belong to the old interrupt.
    assign edge_acc   = rise & ~busy;
    assign set_pend   = edge_acc & ~pending_q;
    assign miss_event = edge_acc & pending_q;
    assign w1c_pend   = wr_stat & apb.pwdata[0] & pending_q & ~busy;
    // A coincident accepted edge beats the software clear.
    assign start_clr  = w1c_pend & ~edge_acc;
    assign clr_miss   = wr_ctrl & apb.pwdata[16];

    // ------------------------------------------------------------------
    // Clear handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_clr) begin
                    state_d   = StClr;
                    len_cnt_d = '0;
                end
            end
            StClr: begin
                if (len_cnt_q == LenLast) begin
                    state_d   = StWait;
                    tmo_cnt_d = '0;
                end else begin
                    len_cnt_d = len_cnt_q + 4'd1;
                end
            end
            StWait: begin
                if (!led_int_i) begin
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_hit = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for status bits
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (set_pend) begin
            pending_d = 1'b1;
        end else if (start_clr) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        clr_tmo_d = clr_tmo_q;
        // A timeout landing on the same edge as its W1C stays visible.
        if (tmo_hit) begin
            clr_tmo_d = 1'b1;
        end else if (wr_stat && apb.pwdata[1]) begin
            clr_tmo_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            len_cnt_q <= '0;
            tmo_cnt_q <= '0;
            div_q     <= '0;
            wren_q    <= 1'b0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            clr_tmo_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            led_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_cnt_q <= len_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            wren_q    <= wr_div;
            if (wr_div) begin
                div_q <= apb.pwdata[11:0];
            end
            pending_q <= pending_d;
            if (set_pend) begin
                snap_q <= int_cnt_i;
            end
            clr_tmo_q <= clr_tmo_d;
            if (wr_ctrl) begin
                irq_en_q <= apb.pwdata[0];
            end
            irq_q <= pending_q & irq_en_q;
            led_q <= led_int_i;
            // Registered so int_clr_o is glitch-free and drops with the async reset.
            clr_q <= (state_d == StClr);
        end
    end

    // ------------------------------------------------------------------
    // Missed-edge counter
    // ------------------------------------------------------------------
    logic unused_miss;
`ifdef LED_CTRL_MISS_CNT_EN
    logic [7:0] miss_q;

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            miss_q <= '0;
        end else if (clr_miss) begin
            miss_q <= '0;
        end else if (miss_event && (miss_q != 8'hff)) begin
            miss_q <= miss_q + 8'd1;
        end
    end

    assign miss_cnt    = miss_q;
    assign unused_miss = 1'b0;
`else
    assign miss_cnt    = 8'd0;
    assign unused_miss = miss_event ^ clr_miss;
`endif

    // ------------------------------------------------------------------
    // Read mux and APB response
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (access) begin
            case (addr)
                2'd0:    rdata = {20'd0, div_q};
                2'd1:    rdata = snap_q;
                2'd2:    rdata = {29'd0, busy, clr_tmo_q, pending_q};
                default: rdata = {16'd0, miss_cnt, 7'd0, irq_en_q};
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = wr_snap;

    assign div_o     = div_q;
    assign wren_o    = wren_q;
    assign int_clr_o = clr_q;
    assign irq_o     = irq_q;

    logic unused_bits;
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[31:17], apb.pwdata[15:12]};

endmodule
